// File: rtl/bus2st_lanes.sv
// Bus-to-stream unpacker: slices BUS_W-bit bus words into ST-bit samples and
// emits LANES samples per beat on a valid/ready stream with sop/eop/keep.
module bus2st_lanes #(
  parameter int BUS_W   = 512,
  parameter int ST      = 12,
  parameter int LANES   = 1,
  parameter int MAX_PKT = 6144
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [BUS_W-1:0]               bus_data,
  input  logic                           bus_valid,
  output logic                           bus_ready,
  input  logic [$clog2(MAX_PKT+1)-1:0]   cfg_pkt_len,
  output logic [LANES*ST-1:0]            st_data,
  output logic                           st_valid,
  input  logic                           st_ready,
  output logic                           st_sop,
  output logic                           st_eop,
  output logic [LANES-1:0]               st_keep,
  output logic                           pkt_done,
  output logic [15:0]                    pkt_cnt,
  output logic                           err_len
);

  localparam int SPB = BUS_W / ST;
  localparam int LW  = $clog2(MAX_PKT + 1);
  localparam int WW  = $clog2(SPB + 1);

  if ((BUS_W / ST) % LANES != 0) begin : g_bad_lanes
    $error("bus2st_lanes: samples per bus word must be a multiple of LANES");
  end

  typedef enum logic {EMPTY, ACTIVE} state_t;

  state_t            state_q, state_d;
  logic [BUS_W-1:0]  hold_q, hold_d;
  logic [WW-1:0]     widx_q, widx_d;
  logic [LW-1:0]     scnt_q, scnt_d;
  logic [LW-1:0]     len_q, len_d;
  logic              open_q, open_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;

  logic              active;
  logic [LW:0]       scnt_nx;
  logic              eop_beat;
  logic              last_word;
  logic              beat_hs;
  logic              word_acc;
  logic              cfg_zero;
  logic              cfg_big;

  assign active    = (state_q == ACTIVE);
  assign scnt_nx   = (LW+1)'(scnt_q) + (LW+1)'(LANES);
  assign eop_beat  = (scnt_nx >= (LW+1)'(len_q));
  assign last_word = ((widx_q + WW'(LANES)) == WW'(SPB)) || eop_beat;
  assign beat_hs   = active && st_ready;
  assign bus_ready = !rst && (!active || (st_ready && last_word));
  assign word_acc  = bus_valid && bus_ready;
  assign cfg_zero  = (cfg_pkt_len == '0);
  assign cfg_big   = (cfg_pkt_len > LW'(MAX_PKT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      hold_q  <= '0;
      widx_q  <= '0;
      scnt_q  <= '0;
      len_q   <= '0;
      open_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      widx_q  <= widx_d;
      scnt_q  <= scnt_d;
      len_q   <= len_d;
      open_q  <= open_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    widx_d  = widx_q;
    scnt_d  = scnt_q;
    len_d   = len_q;
    open_d  = open_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (beat_hs) begin
      scnt_d = scnt_nx[LW-1:0];
      widx_d = widx_q + WW'(LANES);
      if (eop_beat) begin
        done_d = 1'b1;
        cnt_d  = cnt_q + 16'd1;
        open_d = 1'b0;
      end
      if (last_word) state_d = EMPTY;
    end

    if (word_acc) begin
      hold_d  = bus_data;
      widx_d  = '0;
      state_d = ACTIVE;
      // open_d already reflects an eop closing the packet in this same cycle
      if (!open_d) begin
        err_d  = cfg_zero || cfg_big;
        scnt_d = '0;
        len_d  = cfg_big ? LW'(MAX_PKT) : cfg_pkt_len;
        if (cfg_zero) state_d = EMPTY;
        else          open_d  = 1'b1;
      end
    end
  end

  always_comb begin
    st_data = '0;
    st_keep = '0;
    if (active) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        st_data[j*ST +: ST] = hold_q[(32'(widx_q) + j)*ST +: ST];
        st_keep[j]          = ((LW+1)'(scnt_q) + (LW+1)'(j)) < (LW+1)'(len_q);
      end
    end
  end

  assign st_valid = active;
  assign st_sop   = active && (scnt_q == '0);
  assign st_eop   = active && eop_beat;
  assign pkt_done = done_q;
  assign pkt_cnt  = cnt_q;
  assign err_len  = err_q;

endmodule

// File: tb/tb_bus2st_lanes.sv
// Randomised bench for bus2st_lanes: a packet-level model predicts every beat,
// bus_ready and status pulse, checked each cycle on a LANES=1 and a LANES=6 DUT.
module tb_bus2st_lanes;

  localparam int SPB = 42;
  localparam int MAXP = 6144;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst1, rst6, bus_valid1, bus_valid6, st_ready1, st_ready6;
  logic [511:0] bus_data;
  logic [12:0]  cfg;
  logic         bus_ready1, bus_ready6;
  logic [11:0]  d1;
  logic [71:0]  d6;
  logic         v1, v6, sop1, sop6, eop1, eop6, done1, done6, err1, err6;
  logic [0:0]   k1;
  logic [5:0]   k6;
  logic [15:0]  cnt1, cnt6;

  bus2st_lanes u_dut1 (
    .clk(clk), .rst(rst1), .bus_data(bus_data), .bus_valid(bus_valid1),
    .bus_ready(bus_ready1), .cfg_pkt_len(cfg), .st_data(d1), .st_valid(v1),
    .st_ready(st_ready1), .st_sop(sop1), .st_eop(eop1), .st_keep(k1),
    .pkt_done(done1), .pkt_cnt(cnt1), .err_len(err1)
  );

  bus2st_lanes #(.LANES(6)) u_dut6 (
    .clk(clk), .rst(rst6), .bus_data(bus_data), .bus_valid(bus_valid6),
    .bus_ready(bus_ready6), .cfg_pkt_len(cfg), .st_data(d6), .st_valid(v6),
    .st_ready(st_ready6), .st_sop(sop6), .st_eop(eop6), .st_keep(k6),
    .pkt_done(done6), .pkt_cnt(cnt6), .err_len(err6)
  );

  int sel = 0;
  logic [71:0] o_data;
  logic [5:0]  o_keep;
  logic        o_valid, o_sop, o_eop, o_done, o_err, o_bready;
  logic [15:0] o_cnt;
  assign o_data   = (sel != 0) ? d6 : {60'b0, d1};
  assign o_keep   = (sel != 0) ? k6 : {5'b0, k1};
  assign o_valid  = (sel != 0) ? v6 : v1;
  assign o_sop    = (sel != 0) ? sop6 : sop1;
  assign o_eop    = (sel != 0) ? eop6 : eop1;
  assign o_done   = (sel != 0) ? done6 : done1;
  assign o_err    = (sel != 0) ? err6 : err1;
  assign o_cnt    = (sel != 0) ? cnt6 : cnt1;
  assign o_bready = (sel != 0) ? bus_ready6 : bus_ready1;

  typedef struct {
    logic [71:0] data;
    logic [5:0]  keep;
    bit          sop;
    bit          eop;
    bit          lastw;
  } beat_t;

  typedef struct {
    logic [511:0] data;
    logic [12:0]  cfg;
    bit           err;
    int           nb;
  } word_t;

  beat_t       bq[$];
  word_t       wq[$];
  logic [11:0] last_flat[$];

  int          n_chk = 0;
  int          n_pass = 0;
  int          acc = 0;
  bit          exp_done = 0;
  bit          exp_err = 0;
  bit          post_rst = 1;
  logic [15:0] exp_cnt = '0;

  int          beats, hs_cnt, first_cyc, last_cyc, err_seen;
  int          sop_pos[$];
  int          eop_pos[$];
  logic [71:0] last_data;
  logic [5:0]  last_keep;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [511:0] rand_word();
    logic [511:0] w;
    for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // Packet-level model: flat sample list, beats of L lanes, tail lanes still show word samples.
  task automatic add_pkt(input int cfg_len, input int L);
    int          elen, nw, nb, idx;
    bit          err;
    word_t       ws[$];
    word_t       w;
    beat_t       bt;
    logic [11:0] flat[$];
    err  = (cfg_len == 0) || (cfg_len > MAXP);
    elen = (cfg_len > MAXP) ? MAXP : cfg_len;
    if (elen == 0) begin
      w.data = rand_word(); w.cfg = 13'(cfg_len); w.err = 1'b1; w.nb = 0;
      wq.push_back(w);
      return;
    end
    nw = (elen + SPB - 1) / SPB;
    nb = (elen + L - 1) / L;
    for (int i = 0; i < nw; i++) begin
      w.data = rand_word();
      w.cfg  = (i == 0) ? 13'(cfg_len) : 13'($urandom);
      w.err  = (i == 0) && err;
      w.nb   = 0;
      for (int s = 0; s < SPB; s++) flat.push_back(w.data[s*12 +: 12]);
      ws.push_back(w);
    end
    for (int b = 0; b < nb; b++) begin
      bt.data = '0;
      bt.keep = '0;
      for (int j = 0; j < L; j++) begin
        idx = b*L + j;
        bt.data[j*12 +: 12] = flat[idx];
        bt.keep[j] = (idx < elen);
      end
      bt.sop   = (b == 0);
      bt.eop   = (b == nb - 1);
      bt.lastw = bt.eop || (((b + 1) * L) % SPB == 0);
      ws[(b*L)/SPB].nb = ws[(b*L)/SPB].nb + 1;
      bq.push_back(bt);
    end
    foreach (ws[i]) wq.push_back(ws[i]);
    last_flat = flat;
  endtask

  task automatic apply(input bit r, input bit bv, input bit sr);
    if (sel == 0) begin
      rst1 = r; bus_valid1 = bv; st_ready1 = sr;
      rst6 = 1'b1; bus_valid6 = 1'b0; st_ready6 = 1'b0;
    end else begin
      rst6 = r; bus_valid6 = bv; st_ready6 = sr;
      rst1 = 1'b1; bus_valid1 = 1'b0; st_ready1 = 1'b0;
    end
  endtask

  task automatic run(input int p_ready, input int p_valid, input int rst_beat, input int budget);
    int    cyc = 0;
    int    tail = 2;
    bit    did_rst = 0;
    bit    sr, bv, br, doing;
    beat_t hd;
    word_t w;
    beats = 0; hs_cnt = 0; first_cyc = -1; last_cyc = -1; err_seen = 0;
    sop_pos.delete(); eop_pos.delete();
    while ((bq.size() > 0 || wq.size() > 0 || tail > 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bq.size() == 0 && wq.size() == 0) tail--;
      chk("st_valid", o_valid, acc > 0);
      if (acc > 0) begin
        chk("st_data", o_data, bq[0].data);
        chk("st_keep", o_keep, bq[0].keep);
        chk("st_sop", o_sop, bq[0].sop);
        chk("st_eop", o_eop, bq[0].eop);
      end else if (post_rst) begin
        chk("rst_data", o_data, 0);
        chk("rst_keep", o_keep, 0);
        chk("rst_sop", o_sop, 0);
        chk("rst_eop", o_eop, 0);
      end
      chk("pkt_done", o_done, exp_done);
      chk("err_len", o_err, exp_err);
      chk("pkt_cnt", o_cnt, exp_cnt);
      if (o_err) err_seen++;
      post_rst = 0;

      sr = ($urandom_range(99) < p_ready);
      bv = (wq.size() > 0) && ($urandom_range(99) < p_valid);
      bus_data = (wq.size() > 0) ? wq[0].data : rand_word();
      cfg      = (wq.size() > 0) ? wq[0].cfg : 13'($urandom);
      doing = !did_rst && (rst_beat >= 0) && (beats == rst_beat);
      apply(doing, bv, sr);
      #1;
      br = o_bready;
      chk("bus_ready", br, doing ? 1'b0 : ((acc == 0) || (sr && bq[0].lastw)));

      exp_done = 0;
      exp_err  = 0;
      if (doing) begin
        bq.delete(); wq.delete();
        acc = 0; exp_cnt = '0; did_rst = 1; post_rst = 1;
      end else begin
        if (acc > 0 && sr) begin
          hd = bq.pop_front();
          acc--;
          if (hd.sop) sop_pos.push_back(beats);
          if (hd.eop) begin
            eop_pos.push_back(beats);
            exp_done = 1;
            exp_cnt++;
          end
          last_data = hd.data;
          last_keep = hd.keep;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          beats++;
        end
        if (bv && br) begin
          w = wq.pop_front();
          acc += w.nb;
          exp_err = w.err;
          hs_cnt++;
        end
      end
    end
    chk("timeout_left", bq.size() + wq.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_data = '0;
    cfg = '0;
    apply(1'b1, 1'b0, 1'b0);
    rst1 = 1'b1;
    repeat (3) @(negedge clk);

    // Full 1028-sample packet, no backpressure
    add_pkt(1028, 1);
    run(100, 100, -1, 5000);
    chk("t1_beats", beats, 1028);
    chk("t1_words", hs_cnt, 25);
    chk("t1_gapless", last_cyc - first_cyc + 1, 1028);
    chk("t1_sop_cnt", sop_pos.size(), 1);
    chk("t1_eop_cnt", eop_pos.size(), 1);
    if (eop_pos.size() > 0) chk("t1_eop_at", eop_pos[0], 1027);
    chk("t1_last_sample", last_data[11:0], last_flat[24*SPB + 19]);
    chk("t1_pkt_cnt", o_cnt, 1);

    // Same packet with random backpressure and bus gaps
    add_pkt(1028, 1);
    run(50, 70, -1, 20000);
    chk("t2_beats", beats, 1028);
    chk("t2_words", hs_cnt, 25);
    chk("t2_pkt_cnt", o_cnt, 2);

    // Zero length is discarded, then a one-word packet
    add_pkt(0, 1);
    add_pkt(42, 1);
    run(60, 80, -1, 3000);
    chk("t3_err_pulses", err_seen, 1);
    chk("t3_beats", beats, 42);
    chk("t3_words", hs_cnt, 2);
    if (eop_pos.size() > 0) chk("t3_eop_at", eop_pos[0], 41);
    chk("t3_pkt_cnt", o_cnt, 3);

    // Over-long length clamps to MAX_PKT
    add_pkt(7000, 1);
    run(90, 90, -1, 20000);
    chk("t_clamp_err", err_seen, 1);
    chk("t_clamp_beats", beats, 6144);
    chk("t_clamp_words", hs_cnt, 147);

    // Reset mid-packet, then a fresh packet
    add_pkt(1028, 1);
    run(70, 90, 500, 5000);
    chk("t4_beats_before_rst", beats, 500);
    chk("t4_cnt_cleared", o_cnt, 0);
    add_pkt(50, 1);
    run(100, 100, -1, 1000);
    chk("t4_beats_after", beats, 50);
    if (sop_pos.size() > 0) chk("t4_sop_at", sop_pos[0], 0);
    chk("t4_pkt_cnt", o_cnt, 1);

    // Two back-to-back 84-sample packets
    add_pkt(84, 1);
    add_pkt(84, 1);
    run(100, 100, -1, 1000);
    chk("t5_beats", beats, 168);
    chk("t5_gapless", last_cyc - first_cyc + 1, 168);
    chk("t5_eop_cnt", eop_pos.size(), 2);
    if (eop_pos.size() == 2) begin
      chk("t5_eop0", eop_pos[0], 83);
      chk("t5_eop1", eop_pos[1], 167);
    end
    if (sop_pos.size() == 2) chk("t5_sop1", sop_pos[1], 84);
    chk("t5_pkt_cnt", o_cnt, 3);

    // Random packet mix
    for (int p = 0; p < 6; p++) begin
      add_pkt(($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 300)), 1);
      add_pkt(int'($urandom_range(1, 200)), 1);
      run(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), -1, 4000);
    end

    // Multi-lane instance
    sel = 1;
    acc = 0; exp_cnt = '0; exp_done = 0; exp_err = 0; post_rst = 1;
    add_pkt(100, 6);
    run(100, 100, -1, 500);
    chk("t6_beats", beats, 17);
    chk("t6_words", hs_cnt, 3);
    chk("t6_last_keep", last_keep, 6'b001111);
    if (eop_pos.size() > 0) chk("t6_eop_at", eop_pos[0], 16);
    chk("t6_pkt_cnt", o_cnt, 1);
    add_pkt(250, 6);
    add_pkt(84, 6);
    add_pkt(5, 6);
    run(55, 65, -1, 3000);
    chk("t6b_pkt_cnt", o_cnt, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
